// File: rtl/intr_pkg.sv
// -----------------------------------------------------------------------------
// intr_pkg
// Shared definitions for the interrupt controller:
//   - FSM state encoding (IDLE / REQ / SERVE)
//   - memory-mapped register address map
//   - interrupt source index constants
//   - zero-extension helper used by the register read mux
// -----------------------------------------------------------------------------
package intr_pkg;

    localparam int NUM_SRC = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_SERVE = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_PENDING = 2'd0;
    localparam logic [1:0] ADDR_MASK    = 2'd1;
    localparam logic [1:0] ADDR_CAUSE   = 2'd2;
    localparam logic [1:0] ADDR_EOI     = 2'd3;

    localparam int SRC_KEYPAD = 0;
    localparam int SRC_TIMER  = 1;
    localparam int SRC_UART   = 2;
    localparam int SRC_EXT    = 3;

    function automatic logic [31:0] zext4(input logic [3:0] v);
        return {28'd0, v};
    endfunction

endpackage

// File: rtl/intr_prio_enc.sv
// -----------------------------------------------------------------------------
// intr_prio_enc
// 4-bit priority encoder, lowest set index wins.
// Ports:
//   req   [3:0] in   request vector
//   idx   [1:0] out  index of lowest set bit (0 when none set)
//   valid       out  any request bit set
// -----------------------------------------------------------------------------
module intr_prio_enc (
    input  logic [3:0] req,
    output logic [1:0] idx,
    output logic       valid
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) begin
                idx = 2'(i);
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/intr_ctrl.sv
// -----------------------------------------------------------------------------
// intr_ctrl
// Four-source edge-triggered interrupt controller with pending/mask/cause
// registers and a non-nesting IDLE -> REQ -> SERVE handshake with the CPU.
// Ports:
//   clk            in   system clock, rising edge
//   srst           in   synchronous active-high reset
//   irq_src [3:0]  in   raw source levels; a 0->1 transition is an event
//   inta           in   CPU acknowledge pulse
//   intr           out  registered interrupt request
//   wr_en          in   register write strobe
//   addr    [1:0]  in   0 PENDING (W1C), 1 MASK, 2 CAUSE (RO), 3 EOI (WO)
//   wr_data [31:0] in   write data, bits [3:0] used
//   rd_data [31:0] out  combinational read of the selected register
// -----------------------------------------------------------------------------
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int NSRC = 4
) (
    input  logic            clk,
    input  logic            srst,
    input  logic [NSRC-1:0] irq_src,
    input  logic            inta,
    output logic            intr,
    input  logic            wr_en,
    input  logic [1:0]      addr,
    input  logic [31:0]     wr_data,
    output logic [31:0]     rd_data
);

    state_t          state_reg,   state_next;
    logic            intr_reg,    intr_next;
    logic [NSRC-1:0] pending_reg, pending_next;
    logic [NSRC-1:0] mask_reg,    mask_next;
    logic [2:0]      cause_reg,   cause_next;   // {valid, index[1:0]}
    logic [NSRC-1:0] src_q_reg;

    logic [NSRC-1:0] evt;
    logic [NSRC-1:0] w1c_clr;
    logic [NSRC-1:0] grant_clr;
    logic [NSRC-1:0] active;
    logic [1:0]      grant_idx;
    logic            any_active;
    logic            eoi_wr;

    logic            unused_wr_bits;
    assign unused_wr_bits = ^wr_data[31:NSRC];

    // Rising-edge detection per source against the previous sample.
    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_edge
            assign evt[gi]     = irq_src[gi] & ~src_q_reg[gi];
            assign w1c_clr[gi] = wr_en && (addr == ADDR_PENDING) && wr_data[gi];
        end
    endgenerate

    assign active = pending_reg & mask_reg;
    assign eoi_wr = wr_en && (addr == ADDR_EOI);

    intr_prio_enc u_prio (
        .req   (active),
        .idx   (grant_idx),
        .valid (any_active)
    );

    always_comb begin
        state_next = state_reg;
        intr_next  = intr_reg;
        cause_next = cause_reg;
        mask_next  = mask_reg;
        grant_clr  = '0;

        if (wr_en && (addr == ADDR_MASK)) begin
            mask_next = wr_data[NSRC-1:0];
        end

        case (state_reg)
            ST_IDLE: begin
                intr_next = 1'b0;
                if (any_active) begin
                    state_next = ST_REQ;
                    intr_next  = 1'b1;
                end
            end
            ST_REQ: begin
                // A grant needs something to grant; if the enabled set has
                // drained, the request is withdrawn instead.
                if (inta && any_active) begin
                    state_next           = ST_SERVE;
                    intr_next            = 1'b0;
                    cause_next           = {1'b1, grant_idx};
                    grant_clr[grant_idx] = 1'b1;
                end else if (!any_active) begin
                    state_next = ST_IDLE;
                    intr_next  = 1'b0;
                end
            end
            ST_SERVE: begin
                intr_next = 1'b0;
                if (eoi_wr) begin
                    state_next    = ST_IDLE;
                    cause_next[2] = 1'b0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                intr_next  = 1'b0;
            end
        endcase

        // Clears are applied first so a same-cycle event always wins.
        pending_next = (pending_reg & ~(w1c_clr | grant_clr)) | evt;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg   <= ST_IDLE;
            intr_reg    <= 1'b0;
            pending_reg <= '0;
            mask_reg    <= '0;
            cause_reg   <= '0;
            src_q_reg   <= irq_src;   // levels already high do not count as events
        end else begin
            state_reg   <= state_next;
            intr_reg    <= intr_next;
            pending_reg <= pending_next;
            mask_reg    <= mask_next;
            cause_reg   <= cause_next;
            src_q_reg   <= irq_src;
        end
    end

    assign intr = intr_reg;

    always_comb begin
        rd_data = 32'd0;
        case (addr)
            ADDR_PENDING: rd_data = zext4(pending_reg);
            ADDR_MASK:    rd_data = zext4(mask_reg);
            ADDR_CAUSE:   rd_data = {cause_reg[2], 29'd0, cause_reg[1:0]};
            default:      rd_data = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_intr_ctrl
// Directed bench for intr_ctrl. Expected values are pushed onto a scoreboard
// queue alongside the stimulus and popped when the DUT output is sampled.
// -----------------------------------------------------------------------------
module tb_intr_ctrl;
    import intr_pkg::*;

    logic        clk = 1'b0;
    logic        srst;
    logic [3:0]  irq_src;
    logic        inta;
    logic        intr;
    logic        wr_en;
    logic [1:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    intr_ctrl #(.NSRC(4)) dut (
        .clk     (clk),
        .srst    (srst),
        .irq_src (irq_src),
        .inta    (inta),
        .intr    (intr),
        .wr_en   (wr_en),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data)
    );

    always #5 clk = ~clk;

    task automatic expect_val(input string tag, input logic [31:0] e);
        exp_t item;
        item.tag = tag;
        item.exp = e;
        sb.push_back(item);
    endtask

    task automatic check_val(input logic [31:0] obs);
        exp_t item;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty observed=0x%08h required=none", obs);
            return;
        end
        item = sb.pop_front();
        assert (obs === item.exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", item.tag, obs, item.exp);
        end
        $display("chk %-14s observed=0x%08h expected=0x%08h", item.tag, obs, item.exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_intr(input string tag, input logic e);
        expect_val(tag, {31'd0, e});
        check_val({31'd0, intr});
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] e);
        addr = a;
        expect_val(tag, e);
        #1;
        check_val(rd_data);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        addr    = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        wr_data = 32'd0;
    endtask

    task automatic pulse(input logic [3:0] bits);
        irq_src = irq_src | bits;
        tick();
        irq_src = irq_src & ~bits;
    endtask

    task automatic ack();
        inta = 1'b1;
        tick();
        inta = 1'b0;
    endtask

    task automatic do_reset();
        srst = 1'b1;
        tick();
        tick();
        srst = 1'b0;
    endtask

    initial begin
        srst    = 1'b1;
        irq_src = 4'd0;
        inta    = 1'b0;
        wr_en   = 1'b0;
        addr    = 2'd0;
        wr_data = 32'd0;

        // Reset state
        do_reset();
        chk_intr("rst_intr", 1'b0);
        chk_reg("rst_pending", ADDR_PENDING, 32'h0);
        chk_reg("rst_mask",    ADDR_MASK,    32'h0);
        chk_reg("rst_cause",   ADDR_CAUSE,   32'h0);

        // Single timer event, grant, EOI
        wr(ADDR_MASK, 32'hF);
        chk_reg("mask_rd", ADDR_MASK, 32'hF);
        pulse(4'b0010);
        chk_reg("t1_pending", ADDR_PENDING, 32'h2);
        chk_intr("t1_intr_n", 1'b0);
        tick();
        chk_intr("t1_intr_n1", 1'b1);
        ack();
        chk_reg("t1_cause", ADDR_CAUSE, 32'h8000_0001);
        chk_reg("t1_pend_clr", ADDR_PENDING, 32'h0);
        chk_intr("t1_intr_low", 1'b0);
        wr(ADDR_EOI, 32'h0);
        chk_reg("t1_cause_eoi", ADDR_CAUSE, 32'h0000_0001);
        tick();
        chk_intr("t1_idle", 1'b0);

        // Simultaneous sources 3 and 0: lowest index first
        pulse(4'b1001);
        tick();
        chk_intr("t2_intr", 1'b1);
        ack();
        chk_reg("t2_cause0", ADDR_CAUSE, 32'h8000_0000);
        chk_reg("t2_pend", ADDR_PENDING, 32'h8);
        wr(ADDR_EOI, 32'h0);
        chk_intr("t2_eoi_low", 1'b0);
        tick();
        chk_intr("t2_rereq", 1'b1);
        ack();
        chk_reg("t2_cause3", ADDR_CAUSE, 32'h8000_0003);
        chk_reg("t2_pend0", ADDR_PENDING, 32'h0);
        wr(ADDR_EOI, 32'h0);

        // Masked source latches pending but does not request
        wr(ADDR_MASK, 32'h0);
        pulse(4'b0100);
        tick();
        chk_reg("t3_pending", ADDR_PENDING, 32'h4);
        chk_intr("t3_masked", 1'b0);
        wr(ADDR_MASK, 32'h4);
        chk_intr("t3_wr_edge", 1'b0);
        tick();
        chk_intr("t3_unmasked", 1'b1);
        ack();
        chk_reg("t3_cause", ADDR_CAUSE, 32'h8000_0002);
        wr(ADDR_EOI, 32'h0);

        // W1C withdraws the request; late inta ignored
        do_reset();
        wr(ADDR_MASK, 32'hF);
        pulse(4'b0010);
        tick();
        chk_intr("t4_intr", 1'b1);
        wr(ADDR_PENDING, 32'h2);
        chk_reg("t4_w1c", ADDR_PENDING, 32'h0);
        tick();
        chk_intr("t4_drop", 1'b0);
        ack();
        chk_reg("t4_cause", ADDR_CAUSE, 32'h0);
        chk_intr("t4_ign_inta", 1'b0);
        tick();
        chk_intr("t4_still_low", 1'b0);

        // Event coincident with the grant of the same source
        pulse(4'b0010);
        tick();
        chk_intr("t5_intr", 1'b1);
        irq_src = 4'b0010;
        ack();
        irq_src = 4'b0000;
        chk_reg("t5_cause", ADDR_CAUSE, 32'h8000_0001);
        chk_reg("t5_set_wins", ADDR_PENDING, 32'h2);
        chk_intr("t5_low", 1'b0);
        tick();
        chk_intr("t5_no_nest", 1'b0);
        wr(ADDR_EOI, 32'h0);
        tick();
        chk_intr("t5_rereq", 1'b1);
        ack();
        chk_reg("t5_cause2", ADDR_CAUSE, 32'h8000_0001);
        chk_reg("t5_pend0", ADDR_PENDING, 32'h0);
        wr(ADDR_EOI, 32'h0);

        // Reset during SERVE with source 3 pending
        pulse(4'b0010);
        tick();
        pulse(4'b1000);
        ack();
        chk_reg("t6_pending", ADDR_PENDING, 32'h8);
        chk_reg("t6_cause", ADDR_CAUSE, 32'h8000_0001);
        irq_src = 4'b0001;          // held high through reset
        srst = 1'b1;
        tick();
        srst = 1'b0;
        chk_intr("t6_rst_intr", 1'b0);
        chk_reg("t6_rst_pend",  ADDR_PENDING, 32'h0);
        chk_reg("t6_rst_mask",  ADDR_MASK,    32'h0);
        chk_reg("t6_rst_cause", ADDR_CAUSE,   32'h0);
        wr(ADDR_MASK, 32'hF);
        tick();
        tick();
        chk_intr("t6_no_intr", 1'b0);
        chk_reg("t6_no_event", ADDR_PENDING, 32'h0);
        irq_src = 4'b0000;
        tick();
        pulse(4'b0100);
        tick();
        chk_intr("t6_new_evt", 1'b1);

        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_left observed=%0d required=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
